// File: rtl/test_card_pkg.sv
// Shared types and constants for the test card scheduler and its gradient datapath.
package test_card_pkg;

    typedef enum logic [1:0] {
        GRAD  = 2'd0,
        VGRAD = 2'd1,
        HGRAD = 2'd2,
        FLAT  = 2'd3
    } mode_t;

    localparam int unsigned GX_SHIFT = 4;
    localparam int unsigned GY_SHIFT = 1;

    localparam logic [7:0] BASE_RED   = 8'h00;
    localparam logic [7:0] BASE_GREEN = 8'h10;
    localparam logic [7:0] BASE_BLUE  = 8'h4C;

    // FLAT wraps to GRAD through the natural 2-bit overflow.
    function automatic mode_t next_mode(input mode_t m);
        logic [1:0] n;
        n = m + 2'd1;
        return mode_t'(n);
    endfunction

endpackage

// File: rtl/test_card_scheduler_if.sv
// Pixel-domain bundle between the timing generator, the scheduler and the video encoder.
interface test_card_scheduler_if #(
    parameter int unsigned CORDW = 16
);
    logic [CORDW-1:0] i_sx;
    logic [CORDW-1:0] i_sy;
    logic             i_de;
    logic             i_frame;
    logic             i_pause;
    logic             i_next;
    logic             o_de;
    logic [7:0]       o_red;
    logic [7:0]       o_green;
    logic [7:0]       o_blue;
    logic [1:0]       o_mode;
    logic             o_mode_change;

    modport master (
        output i_sx, i_sy, i_de, i_frame, i_pause, i_next,
        input  o_de, o_red, o_green, o_blue, o_mode, o_mode_change
    );

    modport slave (
        input  i_sx, i_sy, i_de, i_frame, i_pause, i_next,
        output o_de, o_red, o_green, o_blue, o_mode, o_mode_change
    );
endinterface

// File: rtl/test_card_gradient.sv
// Combinational gradient colour generator; sums wrap mod 256.
module test_card_gradient
    import test_card_pkg::*;
(
    input  logic [5:0] x,
    input  logic [7:0] y,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    always_comb begin
        red   = BASE_RED + {2'b00, x} + y;
        green = BASE_GREEN + y;
        blue  = BASE_BLUE + y;
    end

endmodule

// File: rtl/test_card_scheduler.sv
// Steps the gradient test card through its display modes and drives a 2-stage pixel pipeline.
module test_card_scheduler
    import test_card_pkg::*;
#(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned HOLD_FRAMES = 120,
    parameter int unsigned CORDW       = 16
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    test_card_scheduler_if.slave  bus
);

    if (H_RES == 0 || H_RES > 1024) begin : g_bad_h_res
        $error("H_RES out of range");
    end
    if (V_RES == 0 || V_RES > 512) begin : g_bad_v_res
        $error("V_RES out of range");
    end
    if (HOLD_FRAMES < 1) begin : g_bad_hold
        $error("HOLD_FRAMES must be at least 1");
    end

    localparam int unsigned CNTW = $clog2(HOLD_FRAMES + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_FRAMES - 1);

    mode_t           mode_q, mode_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            adv;
    logic            chg_q;

    // A request arriving on the frame cycle itself is honoured at that boundary.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        pend_d = pend_q | bus.i_next;
        adv    = 1'b0;
        if (bus.i_frame) begin
            if (pend_d || (cnt_q == CNT_LAST && !bus.i_pause)) begin
                adv    = 1'b1;
                mode_d = next_mode(mode_q);
                cnt_d  = '0;
                pend_d = 1'b0;
            end else if (!bus.i_pause) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            mode_q <= GRAD;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            chg_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            chg_q  <= adv;
        end
    end

    logic [CORDW-1:0] sx_shr, sy_shr;
    logic [5:0]       gx_d, gx_q;
    logic [7:0]       gy_d, gy_q;
    logic             de1_q;

    always_comb begin
        sx_shr = bus.i_sx >> GX_SHIFT;
        sy_shr = bus.i_sy >> GY_SHIFT;
        gx_d   = (sx_shr > CORDW'(63))  ? 6'd63   : sx_shr[5:0];
        gy_d   = (sy_shr > CORDW'(255)) ? 8'd255  : sy_shr[7:0];
        if (mode_q == VGRAD || mode_q == FLAT) gx_d = '0;
        if (mode_q == HGRAD || mode_q == FLAT) gy_d = '0;
    end

    logic [7:0] grad_red, grad_green, grad_blue;

    test_card_gradient u_gradient (
        .x     (gx_q),
        .y     (gy_q),
        .red   (grad_red),
        .green (grad_green),
        .blue  (grad_blue)
    );

    logic       de2_q;
    logic [7:0] red_q, green_q, blue_q;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            gx_q    <= '0;
            gy_q    <= '0;
            de1_q   <= 1'b0;
            de2_q   <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else begin
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            de1_q   <= bus.i_de;
            de2_q   <= de1_q;
            red_q   <= de1_q ? grad_red   : 8'h00;
            green_q <= de1_q ? grad_green : 8'h00;
            blue_q  <= de1_q ? grad_blue  : 8'h00;
        end
    end

    assign bus.o_de          = de2_q;
    assign bus.o_red         = red_q;
    assign bus.o_green       = green_q;
    assign bus.o_blue        = blue_q;
    assign bus.o_mode        = mode_q;
    assign bus.o_mode_change = chg_q;

endmodule

// File: doc/test_card_scheduler.md
# test_card_scheduler

Sequences the gradient test card through a fixed set of display modes, one mode per hold period measured in frames. It maps raw screen coordinates from the display timing generator into the 6-bit x / 8-bit y inputs of `test_card_gradient`, and blanks the output outside the active area. It registers the RGB output so that it stays aligned with display enable. It sits between the display timing generator and the video encoder (DVI/VGA output) in the pixel-clock domain.

## Interface
- `H_RES`, 640: active horizontal pixels. Must be ≤ 1024.
- `V_RES`, 480: active vertical lines. Must be ≤ 512.
- `HOLD_FRAMES`, 120: frames per mode in auto mode. Must be ≥ 1.
- `CORDW`, 16: screen coordinate width.

Ports:
- `clk_pix`  in  1  pixel clock. One clock only.
- `rst_pix`  in  1  reset. Synchronous, active-high.
- `i_sx`  in  CORDW  screen x. Unsigned; valid when `i_de`=1.
- `i_sy`  in  CORDW  screen y. Unsigned; valid when `i_de`=1.
- `i_de`  in  1  display enable (active area).
- `i_frame`  in  1  one-cycle pulse before the first active pixel of each frame.
- `i_pause`  in  1  level; freezes the hold counter.
- `i_next`  in  1  one-cycle pulse; requests advance to the next mode.
- `o_de`  out  1  `i_de` delayed 2 cycles.
- `o_red`, `o_green`, `o_blue`  out  8 each  pixel colour, 2-cycle latency.
- `o_mode`  out  2  current mode.
- `o_mode_change`  out  1  one-cycle pulse after a mode update.

## Operation
- Modes, in order:
  - GRAD=0: x and y both mapped.
  - VGRAD=1: x forced to 0.
  - HGRAD=2: y forced to 0.
  - FLAT=3: x=0, y=0, giving constant colour 00/10/4C.
  - Advancing from FLAT wraps to GRAD.
- Coordinate mapping:
  - gx = min(`i_sx`>>4, 63).
  - gy = min(`i_sy`>>1, 255).
  - The mode then forces gx and/or gy to 0 as listed above.
- Hold counter counts frames, from 0 to HOLD_FRAMES-1:
  - Increments on `i_frame` when `i_pause`=0.
  - Holds its value while `i_pause`=1.
- Pending flag: set by `i_next` and held until consumed. Multiple `i_next` pulses within one frame collapse to a single advance.
- Frame-boundary FSM, evaluated only on cycles where `i_frame`=1:
  - If pending=1, or (counter==HOLD_FRAMES-1 and not paused): mode advances by 1, counter clears to 0, pending clears.
  - Otherwise: counter updates per its rule above and mode is unchanged.
- Manual advance works while paused.
- If `i_next` and `i_frame` occur in the same cycle, the advance happens at that frame boundary, not the next one.
- Expiry and a pending request on the same frame cause one advance, not two.
- The colour sum wraps mod 256, as defined by `test_card_gradient`.

## Timing
- Reset values:
  - `o_red`, `o_green`, `o_blue` = 0.
  - `o_de` = 0, `o_mode_change` = 0.
  - `o_mode` = GRAD, counter = 0, pending = 0.
- Reset mid-frame takes effect on the next edge. The pipeline is flushed, and the output stays black until 2 cycles after reset deasserts.
- Pipeline:
  - Stage 1 registers gx, gy and de.
  - Stage 2 registers RGB from `test_card_gradient`, forced to 0 when stage-1 de=0.
  - Total latency from `i_sx`/`i_sy`/`i_de` to `o_*` is 2 cycles.
- Mode update:
  - The mode register changes on the edge where `i_frame`=1.
  - `o_mode_change`=1 in the following cycle only.
  - Pixels sampled from that following cycle onward use the new mode.
- `i_frame` must precede the first active pixel by ≥1 cycle. Any frame change is then never visible mid-frame.

## Structure
- Package `test_card_pkg` holds:
  - `mode_t` enum (GRAD, VGRAD, HGRAD, FLAT).
  - Coordinate shift constants `GX_SHIFT`=4 and `GY_SHIFT`=1.
  - Base colour constants 00/10/4C, for bench checking.
- One sub-module: an instance of the existing `test_card_gradient`, used as the combinational colour datapath between stage 1 and stage 2.
- The FSM, counter and pending logic stay inline in this block.

## Test plan
- Reset, then GRAD mode; sx=32, sy=20, de=1 → two cycles later RGB = 0x0C/0x1A/0x56, o_de=1.
- FLAT mode, any sx/sy with de=1 → RGB = 00/10/4C. With de=0 → RGB = 0 and o_de=0.
- Clamp check in GRAD: sx=1100, sy=600 → gx=63, gy=255, so red = (0xFF+0x3F) mod 256 = 0x3E.
- HOLD_FRAMES=2, 8 frame pulses → o_mode sequence 0,0→1,1→2,2→3,3→0, with one `o_mode_change` pulse per advance and wrap from FLAT to GRAD.
- `i_pause`=1 for 5 frames → mode is unchanged. Then `i_next`, followed by two further `i_next` pulses in the same frame → exactly one advance at the next `i_frame`.
- Reset asserted mid-frame while in HGRAD → next cycle o_mode=GRAD, RGB=0, o_de=0. Then `i_next` and `i_frame` in the same cycle → a single advance.
